// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_seq_pkg;
  localparam int XLEN         = 32;
  localparam bit EN_RV32M_EXT = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;
endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  // rem < divisor on entry, so the shifted remainder needs one extra bit
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {1'b0, divisor};
    ge      = (rem_sh >= {1'b0, divisor});
    rem_nxt = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ge};
  end
endmodule

// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer; stalls EX for XLEN+1 cycles per op.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN = div_seq_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, rem_nxt, quo_nxt, result_q;
  logic            neg_q, neg_r, is_rem;

  div_op_t         op;
  logic            sgn, a_neg, b_neg, div0, ovf, accept;
  logic [XLEN-1:0] a_abs, b_abs, spec_res, quo_fix, rem_fix;

  always_comb begin
    op       = div_op_t'(op_i);
    sgn      = (op == OP_DIV) || (op == OP_REM);
    a_neg    = sgn && dividend_i[XLEN-1];
    b_neg    = sgn && divisor_i[XLEN-1];
    a_abs    = a_neg ? -dividend_i : dividend_i;
    b_abs    = b_neg ? -divisor_i  : divisor_i;
    div0     = (divisor_i == '0);
    ovf      = sgn && (dividend_i == MIN_NEG) && (&divisor_i);
    // op_i[1] selects remainder
    if (div0) spec_res = op_i[1] ? dividend_i : '1;
    else      spec_res = op_i[1] ? '0 : MIN_NEG;
    accept   = (state == DIV_IDLE) && start_i && !flush_i;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign quo_fix = neg_q ? -quo_nxt : quo_nxt;
  assign rem_fix = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = (div0 || ovf) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == '0) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (flush_i) state_nxt = DIV_IDLE;
  end

  assign stall_req_o = accept || (state == DIV_CALC);
  assign busy_o      = (state != DIV_IDLE);
  assign done_o      = (state == DIV_DONE);
  assign result_o    = result_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      is_rem <= op_i[1];
      if (div0 || ovf) begin
        result_q <= spec_res;
      end else begin
        quo_q <= a_abs;
        dvs_q <= b_abs;
        rem_q <= '0;
        cnt   <= CW'(XLEN-1);
        neg_q <= (op == OP_DIV) && (a_neg ^ b_neg);
        neg_r <= (op == OP_REM) && a_neg;
      end
    end else if (state == DIV_CALC && !flush_i) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) result_q <= is_rem ? rem_fix : quo_fix;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, signs, special cases, flush, reset.
module tb_div_seq;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_req_o, busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  div_seq #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start held while stalled, dropped once stall falls.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int done_cyc = -1;
    int dn = 0;
    int stall_bad = 0;
    logic [31:0] res = '0;
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    for (int c = 0; c <= lat + 2; c++) begin
      #1;
      if (stall_req_o !== (c < lat)) stall_bad++;
      if (done_o === 1'b1) begin
        dn++;
        if (done_cyc < 0) begin done_cyc = c; res = result_o; end
      end
      if (c > 0 && !stall_req_o) start_i = 1'b0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk({tag, "_done_cyc"}, done_cyc, lat);
    chk({tag, "_done_cnt"}, dn, 1);
    chk({tag, "_result"}, res, exp);
    chk({tag, "_stall"}, stall_bad, 0);
  endtask

  initial begin
    int dn;
    int d1, d2, st33, st34;
    logic [31:0] r1, r2;

    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    @(negedge clk_i);

    do_op("divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         33);
    do_op("remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          33);
    do_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    do_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    do_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
    do_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
    do_op("divu_max_1",  2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
    do_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    do_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1);
    do_op("divu_by0",    2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    do_op("remu_by0",    2'b11, 32'd5,          32'd0,          32'd5,          1);
    do_op("div_by0",     2'b00, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1);

    // flush at cycle 10 of CALC
    dn = 0;
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush_i = 1'b1;
      #1;
      if (done_o === 1'b1) dn++;
      @(negedge clk_i);
    end
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    chk("flush_busy", busy_o, 0);
    chk("flush_done", done_o, 0);
    chk("flush_no_pulse", dn, 0);
    do_op("post_flush_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // start held through DONE, second op taken in the following IDLE cycle
    dn = 0; d1 = -1; d2 = -1; st33 = -1; st34 = -1; r1 = '0; r2 = '0;
    op_i = 2'b01; dividend_i = 32'd20; divisor_i = 32'd4; start_i = 1'b1;
    for (int c = 0; c <= 72; c++) begin
      #1;
      if (c == 33) st33 = stall_req_o;
      if (c == 34) st34 = stall_req_o;
      if (done_o === 1'b1) begin
        dn++;
        if (dn == 1) begin d1 = c; r1 = result_o; dividend_i = 32'd21; end
        else if (dn == 2) begin d2 = c; r2 = result_o; start_i = 1'b0; end
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk("b2b_done1_cyc", d1, 33);
    chk("b2b_done2_cyc", d2, 67);
    chk("b2b_res1", r1, 5);
    chk("b2b_res2", r2, 5);
    chk("b2b_pulses", dn, 2);
    chk("b2b_stall_done", st33, 0);
    chk("b2b_stall_accept", st34, 1);

    // synchronous reset during CALC
    dn = 0;
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      #1;
      if (done_o === 1'b1) dn++;
      @(negedge clk_i);
    end
    rst_i = 1'b0; start_i = 1'b0;
    #1;
    if (done_o === 1'b1) dn++;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rstc_busy", busy_o, 0);
    chk("rstc_stall", stall_req_o, 0);
    chk("rstc_result", result_o, 0);
    chk("rstc_done", done_o, 0);
    chk("rstc_no_pulse", dn, 0);
    @(negedge clk_i);
    do_op("post_rst_1000_10", 2'b01, 32'd1000, 32'd10, 32'd100, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 sequencer for the RV32M divide/remainder ops (funct3 100..111) in the execute stage.
- Sits beside the ALU/CMP/MUL units and is selected when EN_RV32M_EXT=1 and the op is a divide or remainder.
- Accepts operands from the id_ex register, holds the pipeline through stall_req_o while iterating, then presents a registered result for one cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  a valid divide/remainder op is present in EX (id_ex valid && div op selected).
- op_i  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  XLEN  rs1 value, already forwarded.
- divisor_i  in  XLEN  rs2 value, already forwarded.
- flush_i  in  1  pipeline flush; aborts any operation in progress.
- stall_req_o  out  1  hold IF/ID/EX.
- busy_o  out  1  FSM is not IDLE.
- done_o  out  1  result_o is valid this cycle.
- result_o  out  XLEN  quotient or remainder.

Behaviour:
- Reset (rst_i=0 at a clock edge): state IDLE, counter 0, all internal registers 0, result_o 0. Combinational outputs follow from IDLE: done_o 0, busy_o 0, stall_req_o 0.
- States:
  - IDLE: accept the op when start_i=1 && flush_i=0.
    - Special case (divisor==0, or DIV/REM with dividend==0x8000_0000 && divisor==0xFFFF_FFFF): load the special result and go to DONE.
    - Otherwise: latch |dividend| and |divisor| (absolute values only for signed ops), latch the quotient-negate and remainder-negate flags, clear the remainder register, set counter=XLEN-1, go to CALC.
  - CALC: one restoring step per cycle.
    - Shift {rem,quo} left by 1, then trial subtract: rem' = rem - divisor.
    - If no borrow, keep rem' and set quo[0]=1.
    - Counter decrements; when it is 0 this cycle, apply sign fix-up, register the result, and go to DONE.
  - DONE: done_o=1 and stall_req_o=0 for exactly one cycle, then return to IDLE. start_i in DONE is ignored: it belongs to the op that is retiring.
- Special results (from the RISC-V spec):
  - Divide by zero: DIV/DIVU give 0xFFFF_FFFF; REM/REMU give dividend_i.
  - Signed overflow: DIV gives 0x8000_0000; REM gives 0.
- Signs:
  - Quotient is negated when DIV and the operand signs differ.
  - Remainder is negated when REM and the dividend is negative.
  - Unsigned ops are never negated.
- stall_req_o is combinational: (IDLE && start_i && !flush_i) || CALC. There is no combinational path from result_o to any input.
- Latency, counting the accept cycle as 0:
  - Normal op: CALC occupies cycles 1..XLEN, DONE is cycle XLEN+1 (33 for XLEN=32), stall is asserted for XLEN+1 cycles.
  - Special op: DONE is cycle 1, stall is asserted for 1 cycle.
- flush_i has priority over everything.
  - In any state, the next state is IDLE and done_o stays 0 on the following cycle.
  - In DONE, done_o is still asserted that cycle; EX qualifies it with its own valid.
  - start_i in the same cycle as flush_i is not accepted.
- Reset mid-CALC returns to IDLE with no done_o pulse.
- Back-to-back divides: a new start_i is accepted in the IDLE cycle right after DONE, so there is one idle bubble between ops.
- busy_o = (state != IDLE).

Decomposition:
- orion_types additions:
  - div_state_t enum: DIV_IDLE, DIV_CALC, DIV_DONE.
  - div_op_t enum: the 2-bit op codes above.
  - Reuse the existing XLEN and EN_RV32M_EXT.
- One natural sub-module: div_step, the combinational shift/trial-subtract slice. Inputs are rem, quo, divisor; outputs are next rem and quo.
- The FSM, counter and sign fix-up live in div_seq.

Test Plan:
- DIVU 100/7, start_i at cycle 0 held while stalled → stall_req_o high for cycles 0..32, done_o only at cycle 33, result_o=14. Repeat with REMU → 2.
- DIV 0xFFFF_FFF9 (-7)/2 → 0xFFFF_FFFD (-3). REM (-7)/2 → 0xFFFF_FFFF (-1). REM 7/(-2) → 1. All with done at cycle 33.
- Special cases, each with done_o at cycle 1 and stall for 1 cycle only:
  - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of same operands → 0.
  - DIVU 5/0 → 0xFFFF_FFFF; REMU 5/0 → 5.
- flush_i at cycle 10 of a CALC → IDLE at cycle 11, no done_o pulse. New DIVU 9/3 started at cycle 11 → 3 at cycle 44.
- start_i held high through DONE, then two back-to-back ops DIVU 20/4 and DIVU 21/4 → results 5 then 5; exactly two done_o pulses, the second op accepted in the IDLE cycle after the first DONE.
- rst_i=0 at cycle 15 of CALC → next cycle: busy_o=0, stall_req_o=0, result_o=0, no done_o; a new op afterwards completes correctly.
